// File: rtl/uart_rx_sampler.sv
// UART receiver: 2-flop rx synchroniser, centre sampling of start/data/parity/stop,
// and a single-entry output register behind a valid/ready handshake with error flags.
module uart_rx_sampler #(
  parameter int unsigned D_WIDTH      = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_O_1   = 0,
  parameter int unsigned CLK_FREQ_MHZ = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [D_WIDTH-1:0] data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overrun,
  output logic               busy
);

  localparam int unsigned BIT_CLKS = CLK_FREQ_MHZ;
  localparam int unsigned HALF     = BIT_CLKS / 2;
  localparam int unsigned CW       = $clog2(BIT_CLKS);
  localparam int unsigned BW       = $clog2(D_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      bitn_q, bitn_d;
  logic [D_WIDTH-1:0] shift_q, shift_d;
  logic               perr_q, perr_d;
  logic [D_WIDTH-1:0] dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               perr_out_q, perr_out_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               stop_sample;
  logic               bit_end, half_end;

  assign bit_end  = (cnt_q == CW'(BIT_CLKS - 1));
  assign half_end = (cnt_q == CW'(HALF - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bitn_d      = bitn_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    dout_d      = dout_q;
    valid_d     = valid_q;
    perr_out_d  = perr_out_q;
    ferr_d      = ferr_q;
    ovr_d       = ovr_q;
    stop_sample = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (half_end) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bitn_d  = '0;
            perr_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[D_WIDTH-1:1]};
          bitn_d  = bitn_q + 1'b1;
          if (bitn_q == BW'(D_WIDTH - 1))
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          perr_d  = rx_s_q ^ (^shift_q) ^ (PARITY_O_1 != 0);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d       = '0;
          stop_sample = 1'b1;
          state_d     = rx_s_q ? S_IDLE : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Handshake is applied first so a same-cycle load wins over the valid drop.
    if (valid_q && data_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (stop_sample) begin
      if (!valid_q || data_ready) begin
        dout_d     = shift_q;
        perr_out_d = perr_q;
        ferr_d     = !rx_s_q;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bitn_q     <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= rx;
      rx_s_q     <= sync1_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitn_q     <= bitn_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed scenarios plus random frames against a
// frame-level reference (even-parity and odd-parity instances share the rx line).
module tb_uart_rx_sampler;

  localparam int unsigned BIT = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out, data_out_o;
  logic       data_valid, parity_err, frame_err, overrun, busy;
  logic       data_valid_o, parity_err_o, frame_err_o, overrun_o, busy_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cycle_cnt = 0;
  int unsigned start_cyc = 0;
  int unsigned rise_cyc  = 0;
  logic        prev_valid = 1'b0;

  uart_rx_sampler #(.D_WIDTH(8), .PARITY_EN(1), .PARITY_O_1(0), .CLK_FREQ_MHZ(50)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy));

  uart_rx_sampler #(.D_WIDTH(8), .PARITY_EN(1), .PARITY_O_1(1), .CLK_FREQ_MHZ(50)) dut_odd (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out_o), .data_valid(data_valid_o),
    .data_ready(data_ready), .parity_err(parity_err_o), .frame_err(frame_err_o),
    .overrun(overrun_o), .busy(busy_o));

  always #10 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  always @(negedge clk) begin
    if (data_valid && !prev_valid) rise_cyc = cycle_cnt;
    prev_valid = data_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic par_even(input logic [7:0] d);
    return ($countones(d) % 2) != 0;
  endfunction

  // Drives the first nbits frame bits (start, data LSB first, parity, stop), BIT cycles each.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int unsigned nbits);
    logic [10:0] fr;
    fr = {s, p, d, 1'b0};
    start_cyc = cycle_cnt;
    for (int unsigned i = 0; i < nbits; i++) begin
      rx = fr[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic handshake();
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s;
    int unsigned gap;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_flags", {parity_err, frame_err, overrun, busy}, 0);
    idle(10);

    // Clean frame 0x55, consumer stalled.
    send_frame(8'h55, par_even(8'h55), 1'b1, 11);
    check("clean_latency", rise_cyc - start_cyc, 528);
    check("clean_data", data_out, 8'h55);
    check("clean_flags", {data_valid, parity_err, frame_err, overrun}, 4'b1000);
    idle(100);
    check("clean_hold", {data_valid, data_out}, {1'b1, 8'h55});
    handshake();
    check("clean_drop", data_valid, 0);

    // Wrong even parity for 0xA7, which is correct odd parity.
    send_frame(8'hA7, 1'b0, 1'b1, 11);
    check("par_data", data_out, 8'hA7);
    check("par_even_err", {parity_err, frame_err}, 2'b10);
    check("par_odd_ok", {data_valid_o, parity_err_o, data_out_o}, {2'b10, 8'hA7});
    idle(5);
    handshake();

    // Framing error then break held low.
    send_frame(8'h3C, par_even(8'h3C), 1'b0, 11);
    repeat (5 * BIT) @(negedge clk);
    check("brk_busy", busy, 1);
    check("brk_word", {data_valid, frame_err, data_out}, {2'b11, 8'h3C});
    handshake();
    idle(5);
    check("brk_idle", busy, 0);
    idle(600);
    check("brk_no_spurious", data_valid, 0);

    // Short glitch shorter than half a bit.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy", busy, 1);
    repeat (5) @(negedge clk);
    idle(20);
    check("glitch_done", {busy, data_valid}, 2'b00);
    idle(600);
    check("glitch_no_word", data_valid, 0);

    // Overrun: two back-to-back frames with no consumer.
    send_frame(8'h11, par_even(8'h11), 1'b1, 11);
    send_frame(8'h22, par_even(8'h22), 1'b1, 11);
    idle(5);
    check("ovr_keep", {data_valid, overrun, data_out}, {2'b11, 8'h11});
    handshake();
    check("ovr_clear", {data_valid, overrun}, 2'b00);
    send_frame(8'h33, par_even(8'h33), 1'b1, 11);
    idle(5);
    check("ovr_next", {data_valid, overrun, parity_err, data_out}, {3'b100, 8'h33});
    handshake();
    idle(20);

    // Reset during data bit 4 with a word pending.
    send_frame(8'h96, par_even(8'h96), 1'b1, 11);
    send_frame(8'h00, 1'b0, 1'b1, 5);
    repeat (BIT / 2) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out", {data_valid, parity_err, frame_err, overrun, busy, data_out}, 0);
    idle(700);
    check("mid_quiet", {data_valid, busy}, 2'b00);
    send_frame(8'h5A, par_even(8'h5A), 1'b1, 11);
    idle(5);
    check("mid_recover", {data_valid, parity_err, frame_err, data_out}, {3'b100, 8'h5A});
    handshake();
    idle(10);

    // Random frames against the frame-level reference.
    for (int k = 0; k < 10; k++) begin
      d   = 8'($urandom_range(0, 255));
      p   = 1'($urandom_range(0, 1));
      s   = ($urandom_range(0, 3) != 0);
      gap = 10 + $urandom_range(0, 30);
      send_frame(d, p, s, 11);
      check("rnd_data", {data_valid, data_out}, {1'b1, d});
      check("rnd_perr_even", parity_err, (($countones(d) + p) % 2) != 0);
      check("rnd_perr_odd", parity_err_o, (($countones(d) + p) % 2) == 0);
      check("rnd_ferr", {frame_err, frame_err_o}, {!s, !s});
      idle(gap);
      handshake();
      check("rnd_drop", {data_valid, data_valid_o, overrun}, 3'b000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Stand-alone UART receiver; the receive end of the team's 1 Mbps, 8-bit, optional-parity serial link.
- Takes the asynchronous rx line, finds the start bit, samples each bit at its centre, and checks parity and the stop bit.
- Presents each received word through a valid/ready handshake with error flags.
- Sits between the pad and the host-side register/FIFO logic; replaces the ad-hoc receive path in the combined UART.

Parameters:
- D_WIDTH, 8, number of data bits per frame, LSB first, legal range 5..9.
- PARITY_EN, 1, 1 means a parity bit follows the data bits; 0 means no parity bit.
- PARITY_O_1, 0, 0 means even parity, 1 means odd parity; ignored when PARITY_EN=0.
- CLK_FREQ_MHZ, 50, clk frequency in MHz; BIT_CLKS = CLK_FREQ_MHZ clocks per bit at 1 Mbps, minimum 4.

Ports:
- clk  input  1  the single clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- rx  input  1  asynchronous serial line; idles high.
- data_out  output  D_WIDTH  received word, valid while data_valid=1.
- data_valid  output  1  word available.
- data_ready  input  1  consumer accepts the word when data_valid & data_ready.
- parity_err  output  1  parity mismatch for the current data_out; qualified by data_valid.
- frame_err  output  1  stop bit sampled low for the current data_out; qualified by data_valid.
- overrun  output  1  sticky; a frame completed while data_valid=1 was still waiting.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. Synchroniser flops reset to 1, FSM to IDLE, counters to 0.
- Reset mid-frame aborts the frame and drops any pending word.
- Input synchroniser: two-flop synchroniser on rx gives rx_s, 2 cycles latency. All decisions use rx_s.
- HALF = BIT_CLKS/2, rounded down. The baud counter restarts on every state entry.
- IDLE: a falling edge of rx_s (previous 1, current 0) moves to START.
- START: wait HALF cycles, then sample rx_s.
  - Sample 1: false start; return to IDLE with no output.
  - Sample 0: go to DATA with bit counter = 0.
- DATA: sample every BIT_CLKS cycles, so each sample lands at a bit centre. Shift right, MSB in, so bit 0 ends in data_out[0]. After D_WIDTH samples, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: sample after BIT_CLKS cycles.
  - perr = sample XOR (XOR of data bits) XOR PARITY_O_1, so even parity expects XOR of data plus parity = 0.
  - When PARITY_EN=0, perr = 0.
- STOP: sample after BIT_CLKS cycles; ferr = ~sample.
  - On the sample cycle the word is delivered (see output register).
  - Then: if the sample was 1, go to IDLE. If it was 0 (break or line fault), go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. No new start is recognised until the line has returned high.
- Sample timing: the falling edge is seen at cycle E on rx_s. Sample point of frame bit k (start=0, data0=1, …) is cycle E+HALF+k*BIT_CLKS. data_valid rises on the cycle after the stop sample.
- Output register, on the stop-sample cycle:
  - If data_valid=0, or data_ready=1 in that same cycle: load data_out, parity_err=perr, frame_err=ferr, and set data_valid=1.
  - Otherwise keep the old word, discard the new one, and set overrun=1.
- Parity and frame errors do not suppress delivery; the word is delivered with its flags.
- Handshake:
  - data_valid falls on the cycle after data_valid & data_ready unless a new load happens in that same cycle.
  - data_out and the flags hold stable while data_valid=1 and data_ready=0.
- overrun clears only on a handshake (data_valid & data_ready) or on rst. It is not cleared by a new load.
- Receive continues regardless of data_valid; back-to-back frames with a single stop bit are supported.

Test Plan:
All scenarios use CLK_FREQ_MHZ=50, D_WIDTH=8, PARITY_EN=1, PARITY_O_1=0, 1000 ns bits.
- Clean frame: send 0x55 with parity 0 and stop 1; hold data_ready=0.
  - data_valid rises at E+25+10*50+1 = E+526.
  - data_out=0x55, parity_err=0, frame_err=0; all hold until data_ready=1, then data_valid=0 on the next cycle.
- Parity error: send 0xA7 with parity bit 0 (correct is 0xA7 XOR = 1 → parity 1).
  - data_out=0xA7, parity_err=1, frame_err=0.
  - Repeat with PARITY_O_1=1 and parity 0: parity_err=0.
- Framing and break: send 0x3C with stop=0, then hold rx low 5 bit times.
  - frame_err=1 with data_out=0x3C.
  - busy stays high until rx returns high; no spurious second word.
- Glitch rejection: rx low pulse of 10 clk (less than HALF).
  - No data_valid; busy returns to 0 within 25+3 cycles of the edge.
- Overrun: send 0x11 then 0x22 back-to-back with data_ready=0.
  - data_out stays 0x11 and overrun=1.
  - A handshake clears overrun and data_valid.
  - The next frame 0x33 is delivered normally.
- Reset mid-frame: assert rst for 1 cycle during data bit 4.
  - All outputs 0, FSM in IDLE.
  - A subsequent clean 0x5A frame is received correctly.
